// File: rtl/letter_stream_feeder_if.sv
// Byte-in / letter-out bundle between an ASCII source, the letter feeder and the
// pattern detector downstream. The master side is the upstream producer plus the consumer.
interface letter_stream_feeder_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             hold;
  logic [7:0]       letter;
  logic             letter_valid;
  logic [LVL_W-1:0] fifo_level;
  logic [CNT_W-1:0] drop_cnt;

  modport master (
    output in_valid, in_data, hold,
    input  in_ready, letter, letter_valid, fifo_level, drop_cnt
  );

  modport slave (
    input  in_valid, in_data, hold,
    output in_ready, letter, letter_valid, fifo_level, drop_cnt
  );
endinterface

// File: rtl/letter_stream_feeder.sv
// Buffers raw ASCII bytes, folds them to upper case and filters non-letters,
// then presents one registered letter per clock to the alphabet pattern detector.
module letter_stream_feeder #(
  parameter int       DEPTH         = 8,
  parameter bit [7:0] IDLE_CHAR     = 8'h20,
  parameter bit       DROP_NONALPHA = 1'b1,
  parameter int       CNT_W         = 8
) (
  input logic                    clk_i,
  input logic                    rst_i,
  letter_stream_feeder_if.slave  feed_if
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [7:0]       letter_q, letter_d;
  logic             letter_valid_q, letter_valid_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic       in_ready;
  logic       accept;
  logic       is_lower;
  logic       is_upper;
  logic       is_alpha;
  logic       push;
  logic       drop;
  logic       pop;
  logic [7:0] norm_byte;

  // Readiness looks only at the stored level, so a pop this cycle never frees a slot early.
  always_comb begin
    in_ready  = !rst_i && (level_q != LVL_W'(DEPTH));
    accept    = feed_if.in_valid && in_ready;
    is_lower  = (feed_if.in_data >= 8'h61) && (feed_if.in_data <= 8'h7A);
    is_upper  = (feed_if.in_data >= 8'h41) && (feed_if.in_data <= 8'h5A);
    is_alpha  = is_lower || is_upper;
    norm_byte = IDLE_CHAR;
    if (is_lower) begin
      norm_byte = feed_if.in_data - 8'h20;
    end else if (is_upper) begin
      norm_byte = feed_if.in_data;
    end
    push = accept && (is_alpha || !DROP_NONALPHA);
    drop = accept && !is_alpha && DROP_NONALPHA;
    pop  = !feed_if.hold && (level_q != '0);
  end

  // Pop decision uses the pre-edge level, so a byte written into an empty FIFO waits one edge.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    level_d        = level_q;
    letter_d       = IDLE_CHAR;
    letter_valid_d = 1'b0;
    drop_cnt_d     = drop_cnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d       = rd_ptr_q + PTR_W'(1);
      letter_d       = mem_q[rd_ptr_q];
      letter_valid_d = 1'b1;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      letter_q       <= IDLE_CHAR;
      letter_valid_q <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      letter_q       <= letter_d;
      letter_valid_q <= letter_valid_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Storage needs no reset; reset empties the FIFO by clearing pointers and level.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= norm_byte;
    end
  end

  assign feed_if.in_ready     = in_ready;
  assign feed_if.letter       = letter_q;
  assign feed_if.letter_valid = letter_valid_q;
  assign feed_if.fifo_level   = level_q;
  assign feed_if.drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_letter_stream_feeder.sv
// Bench for letter_stream_feeder: one instance that drops non-letters (A) and one that
// stores them as idle fill (B), both driven identically and compared to a queue model.
module tb_letter_stream_feeder;
  localparam int       DEPTH = 8;
  localparam int       CNT_W = 8;
  localparam bit [7:0] IDLE  = 8'h20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  letter_stream_feeder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) ifA ();
  letter_stream_feeder_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) ifB ();

  letter_stream_feeder #(.DEPTH(DEPTH), .IDLE_CHAR(IDLE), .DROP_NONALPHA(1'b1), .CNT_W(CNT_W))
    dutA (.clk_i(clk), .rst_i(rst), .feed_if(ifA));
  letter_stream_feeder #(.DEPTH(DEPTH), .IDLE_CHAR(IDLE), .DROP_NONALPHA(1'b0), .CNT_W(CNT_W))
    dutB (.clk_i(clk), .rst_i(rst), .feed_if(ifB));

  int nChecks = 0;
  int nPass   = 0;

  logic [7:0] qA[$];
  logic [7:0] qB[$];
  logic [7:0] expLetA, expLetB;
  logic       expValA, expValB;
  int         cntA;
  logic       accA;
  string      outA;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       h;
    logic [7:0] expLetter;
    logic       expValid;
  } vec_t;
  vec_t vecs[15];

  function automatic bit isLetter(input logic [7:0] b);
    return (b >= "a" && b <= "z") || (b >= "A" && b <= "Z");
  endfunction

  function automatic logic [7:0] toUpper(input logic [7:0] b);
    return (b >= "a" && b <= "z") ? b - ("a" - "A") : b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic checkState();
    checkOutput("letterA", 32'(ifA.letter), 32'(expLetA));
    checkOutput("validA", 32'(ifA.letter_valid), 32'(expValA));
    checkOutput("levelA", 32'(ifA.fifo_level), 32'(qA.size()));
    checkOutput("dropA", 32'(ifA.drop_cnt), 32'(cntA));
    checkOutput("letterB", 32'(ifB.letter), 32'(expLetB));
    checkOutput("validB", 32'(ifB.letter_valid), 32'(expValB));
    checkOutput("levelB", 32'(ifB.fifo_level), 32'(qB.size()));
    checkOutput("dropB", 32'(ifB.drop_cnt), 32'd0);
  endtask

  // One clock: drive, check readiness, advance the model at the edge, check outputs.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic h);
    logic accB;
    ifA.in_valid = v; ifA.in_data = d; ifA.hold = h;
    ifB.in_valid = v; ifB.in_data = d; ifB.hold = h;
    #1;
    checkOutput("readyA", 32'(ifA.in_ready), 32'(qA.size() != DEPTH));
    checkOutput("readyB", 32'(ifB.in_ready), 32'(qB.size() != DEPTH));
    accA = v && (qA.size() != DEPTH);
    accB = v && (qB.size() != DEPTH);
    @(posedge clk);
    if (!h && qA.size() != 0) begin expLetA = qA.pop_front(); expValA = 1'b1; end
    else begin expLetA = IDLE; expValA = 1'b0; end
    if (!h && qB.size() != 0) begin expLetB = qB.pop_front(); expValB = 1'b1; end
    else begin expLetB = IDLE; expValB = 1'b0; end
    if (accA) begin
      if (isLetter(d)) qA.push_back(toUpper(d));
      else if (cntA != 255) cntA++;
    end
    if (accB) qB.push_back(isLetter(d) ? toUpper(d) : IDLE);
    #1;
    checkState();
    if (ifA.letter_valid) outA = {outA, string'(ifA.letter)};
  endtask

  task automatic doReset();
    rst = 1'b1;
    ifA.in_valid = 1'b1; ifA.in_data = "z"; ifA.hold = 1'b0;
    ifB.in_valid = 1'b1; ifB.in_data = "z"; ifB.hold = 1'b0;
    #1;
    checkOutput("rstReadyA", 32'(ifA.in_ready), 32'd0);
    checkOutput("rstReadyB", 32'(ifB.in_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    qA.delete(); qB.delete();
    expLetA = IDLE; expLetB = IDLE; expValA = 1'b0; expValB = 1'b0; cntA = 0;
    checkState();
    outA = "";
  endtask

  initial begin
    string s;
    string expStr;
    int    idx;
    int    guard;
    logic  v;
    logic [7:0] d;
    logic  h;

    ifA.in_valid = 1'b0; ifA.in_data = 8'h00; ifA.hold = 1'b0;
    ifB.in_valid = 1'b0; ifB.in_data = 8'h00; ifB.hold = 1'b0;

    vecs[0]  = '{1'b1, "h", 1'b0, IDLE, 1'b0};
    vecs[1]  = '{1'b1, "o", 1'b0, "H",  1'b1};
    vecs[2]  = '{1'b1, "m", 1'b0, "O",  1'b1};
    vecs[3]  = '{1'b1, "e", 1'b0, "M",  1'b1};
    vecs[4]  = '{1'b1, "w", 1'b0, "E",  1'b1};
    vecs[5]  = '{1'b1, "o", 1'b0, "W",  1'b1};
    vecs[6]  = '{1'b1, "r", 1'b0, "O",  1'b1};
    vecs[7]  = '{1'b1, "k", 1'b0, "R",  1'b1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, "K", 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, IDLE, 1'b0};
    vecs[10] = '{1'b1, "a", 1'b0, IDLE, 1'b0};
    vecs[11] = '{1'b1, "1", 1'b0, "A",  1'b1};
    vecs[12] = '{1'b1, "B", 1'b0, IDLE, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 1'b0, "B", 1'b1};
    vecs[14] = '{1'b0, 8'h00, 1'b0, IDLE, 1'b0};

    doReset();

    // "homework" back to back, then "a1B" with the digit filtered out
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].h);
      checkOutput($sformatf("tblLetter%0d", i), 32'(ifA.letter), 32'(vecs[i].expLetter));
      checkOutput($sformatf("tblValid%0d", i), 32'(ifA.letter_valid), 32'(vecs[i].expValid));
    end
    checkOutput("t2Drop", 32'(ifA.drop_cnt), 32'd1);

    // Fill while held, then release with a byte offered against the full FIFO
    doReset();
    s = "abcdefghij";
    idx = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, s[idx], 1'b1);
      if (accA) idx++;
    end
    checkOutput("t3Level", 32'(ifA.fifo_level), 32'd8);
    checkOutput("t3Ready", 32'(ifA.in_ready), 32'd0);
    checkOutput("t3Letter", 32'(ifA.letter), 32'(IDLE));
    applyStimulus(1'b1, s[idx], 1'b0);
    if (accA) idx++;
    checkOutput("t4Level", 32'(ifA.fifo_level), 32'd7);
    checkOutput("t4Ready", 32'(ifA.in_ready), 32'd1);
    guard = 0;
    while ((idx < 10 || qA.size() != 0) && guard < 50) begin
      applyStimulus(idx < 10, (idx < 10) ? s[idx] : 8'h00, 1'b0);
      if (accA) idx++;
      guard++;
    end
    checkOutput("t3Drained", 32'(guard < 50), 32'd1);
    nChecks++;
    if (outA == "ABCDEFGHIJ") nPass++;
    else $display("[TB] FAIL t3Order: got %s expected ABCDEFGHIJ", outA);

    // Reset with buffered data and a non-zero drop count
    doReset();
    s = "1!2";
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, s[i], 1'b0);
    s = "abcde";
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, s[i], 1'b1);
    checkOutput("t5LevelPre", 32'(ifA.fifo_level), 32'd5);
    checkOutput("t5DropPre", 32'(ifA.drop_cnt), 32'd3);
    doReset();
    checkOutput("t5Level", 32'(ifA.fifo_level), 32'd0);
    checkOutput("t5Letter", 32'(ifA.letter), 32'(IDLE));
    checkOutput("t5Drop", 32'(ifA.drop_cnt), 32'd0);
    applyStimulus(1'b1, "x", 1'b0);
    applyStimulus(1'b1, "y", 1'b0);
    checkOutput("t5Flow", 32'(ifA.letter), 32'("X"));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 1'b0);

    // Random letters, random hold and occasional non-letters
    doReset();
    s = "";
    expStr = "";
    for (int i = 0; i < 20; i++) begin
      d = 8'("A" + $urandom_range(0, 25));
      if ($urandom_range(0, 1) == 1) d = d + 8'h20;
      s = {s, string'(d)};
      expStr = {expStr, string'(toUpper(d))};
    end
    idx = 0;
    guard = 0;
    while ((idx < 20 || qA.size() != 0) && guard < 400) begin
      h = (idx < 20) && ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        applyStimulus(1'b1, 8'("0" + $urandom_range(0, 9)), h);
      end else begin
        v = (idx < 20) && ($urandom_range(0, 3) != 0);
        applyStimulus(v, (idx < 20) ? s[idx] : 8'h00, h);
        if (accA && v) idx++;
      end
      checkOutput("t6LevelMax", 32'(ifA.fifo_level <= 8), 32'd1);
      guard++;
    end
    checkOutput("t6Drained", 32'(guard < 400), 32'd1);
    nChecks++;
    if (outA == expStr) nPass++;
    else $display("[TB] FAIL t6Order: got %s expected %s", outA, expStr);

    // Drop counter saturates at all ones
    for (int i = 0; i < 262; i++) applyStimulus(1'b1, "#", 1'b0);
    checkOutput("dropSat", 32'(ifA.drop_cnt), 32'd255);
    applyStimulus(1'b0, 8'h00, 1'b0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
